// File: rtl/act_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_pkg
// Description : Shared state encoding and default sizes for the activation
//               deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
package act_pkg;

    localparam int c_def_width = 8;
    localparam int c_def_in    = 84;
    localparam int c_def_zw    = 2 * c_def_width + 7;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } act_state_t;

endpackage
`default_nettype wire

// File: rtl/act_requant.sv
`default_nettype none
// ============================================================================
// Module      : act_requant
// Description : Requantizes a non-negative layer result to WIDTH bits by a
//               logical right shift; saturates when ACT_DESER_SAT_EN is set,
//               otherwise truncates.
// Revision    : 1.0 - initial release
// ============================================================================
module act_requant
    import act_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int ZW    = c_def_zw,
    parameter int SHIFT = 8
) (
    input  logic [ZW-1:0]    i_z,
    output logic [WIDTH-1:0] o_q
);

`ifdef ACT_DESER_SAT_EN
    localparam logic [ZW-1:0] c_max = ZW'((1 << (WIDTH - 1)) - 1);

    logic [ZW-1:0] w_shifted;

    assign w_shifted = i_z >> SHIFT;
    assign o_q       = (w_shifted > c_max) ? WIDTH'(c_max) : w_shifted[WIDTH-1:0];
`else
    assign o_q = WIDTH'(i_z >> SHIFT);
`endif

endmodule
`default_nettype wire

// File: rtl/act_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : act_deserializer
// Description : Collects a stream of signed activations into a parallel
//               vector for an external combinational layer, waits for the
//               layer to settle, then returns the requantized result.
//               Optional saturation: define ACT_DESER_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module act_deserializer
    import act_pkg::*;
#(
    parameter int WIDTH  = c_def_width,
    parameter int IN     = c_def_in,
    parameter int ZW     = c_def_zw,
    parameter int SETTLE = 2,
    parameter int SHIFT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] x [0:IN-1],
    input  logic [ZW-1:0]           z_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    err_len
);

    localparam int                 c_idx_w    = $clog2(IN);
    localparam int                 c_cnt_w    = 4;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(IN - 1);
    localparam logic [c_cnt_w-1:0] c_settle   = c_cnt_w'(SETTLE);

    act_state_t                r_state;
    logic [c_idx_w-1:0]        r_idx;
    logic [c_cnt_w-1:0]        r_cnt;
    logic signed [WIDTH-1:0]   r_x [0:IN-1];
    logic                      r_s_ready;
    logic                      r_m_valid;
    logic [WIDTH-1:0]          r_m_data;
    logic                      r_err_len;

    logic                      w_beat;
    logic                      w_idx_end;
    logic [WIDTH-1:0]          w_q;

    assign w_beat    = s_valid && r_s_ready;
    assign w_idx_end = (r_idx == c_idx_last);

    act_requant #(
        .WIDTH (WIDTH),
        .ZW    (ZW),
        .SHIFT (SHIFT)
    ) u_requant (
        .i_z (z_in),
        .o_q (w_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FILL;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_err_len <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_beat) begin
                        r_x[r_idx] <= s_data;
                        // A vector closes on s_last or on a full buffer; a
                        // mismatch between the two is a length error.
                        if (s_last || w_idx_end) begin
                            r_err_len <= s_last ^ w_idx_end;
                            r_state   <= EVAL;
                            r_s_ready <= 1'b0;
                            r_idx     <= '0;
                            r_cnt     <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    if (r_cnt == c_settle) begin
                        r_m_data  <= w_q;
                        r_m_valid <= 1'b1;
                        r_state   <= OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_idx     <= '0;
                        r_state   <= FILL;
                        for (int i = 0; i < IN; i++) begin
                            r_x[i] <= '0;
                        end
                    end
                end
                default: begin
                    r_state   <= FILL;
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign x       = r_x;
    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign err_len = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_act_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_act_deserializer
// Description : Self-checking bench for act_deserializer; expected results
//               follow ACT_DESER_SAT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_deserializer;

    localparam int WIDTH  = 8;
    localparam int IN     = 84;
    localparam int ZW     = 23;
    localparam int SETTLE = 2;
    localparam int SHIFT  = 8;

    typedef struct {
        int              nb;
        int              lastb;
        logic [ZW-1:0]   z;
        logic [WIDTH-1:0] seed;
        int              err;
        int              hold;
    } vec_t;

    logic                    clk     = 1'b0;
    logic                    rst     = 1'b1;
    logic                    s_valid = 1'b0;
    logic                    s_last  = 1'b0;
    logic                    m_ready = 1'b0;
    logic [WIDTH-1:0]        s_data  = '0;
    logic [ZW-1:0]           z_in    = '0;
    logic                    s_ready;
    logic                    m_valid;
    logic                    err_len;
    logic [WIDTH-1:0]        m_data;
    logic signed [WIDTH-1:0] x [0:IN-1];

    int               checks   = 0;
    int               errors   = 0;
    int               err_seen = 0;
    int               err_base;
    int               lingered;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] x_exp [IN];
    vec_t             tbl [6];

    act_deserializer #(
        .WIDTH  (WIDTH),
        .IN     (IN),
        .ZW     (ZW),
        .SETTLE (SETTLE),
        .SHIFT  (SHIFT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .x       (x),
        .z_in    (z_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_len) err_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WIDTH-1:0] model_q(input logic [ZW-1:0] z);
        logic [ZW-1:0] q;
        q = z >> SHIFT;
`ifdef ACT_DESER_SAT_EN
        if (q > ZW'(2 ** (WIDTH - 1) - 1)) return WIDTH'(2 ** (WIDTH - 1) - 1);
`endif
        return q[WIDTH-1:0];
    endfunction

    function automatic bit x_ok();
        for (int i = 0; i < IN; i++) begin
            if (x[i] !== x_exp[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_x_exp();
        for (int i = 0; i < IN; i++) x_exp[i] = '0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one beat and returns #1 after the edge that accepts it.
    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last);
        int t;
        t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("beat_accept_timeout", int'(t < 100), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input int hold, input int exp_err, input int base);
        int               lat;
        logic [WIDTH-1:0] held;
        check("m_valid_low_eval", int'(m_valid), 0);
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, SETTLE + 1);
        if (!m_valid) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        check("x_stable_out", int'(x_ok()), 1);
        held = m_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("out_hold", int'({m_valid, s_ready, m_data}), int'({1'b1, 1'b0, held}));
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("m_data", int'(m_data), int'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("m_valid_after_hs", int'(m_valid), 0);
        check("s_ready_after_hs", int'(s_ready), 1);
        clear_x_exp();
        check("x_cleared", int'(x_ok()), 1);
        check("err_pulses", err_seen - base, exp_err);
    endtask

    task automatic run_vector(input vec_t v);
        int base;
        base = err_seen;
        z_in = v.z;
        exp_q.push_back(model_q(v.z));
        clear_x_exp();
        for (int i = 0; i < v.nb; i++) begin
            send_beat(v.seed + 8'(i), (i + 1) == v.lastb);
            x_exp[i] = v.seed + 8'(i);
        end
        check("x_after_fill", int'(x_ok()), 1);
        check("s_ready_eval", int'(s_ready), 0);
        drain(v.hold, v.err, base);
    endtask

    initial begin
        tbl[0] = '{84, 84, 23'h000500, 8'h00, 0, 0};
        tbl[1] = '{10, 10, 23'h7FFF00, 8'h10, 1, 5};
        tbl[2] = '{84,  0, 23'h0123AB, 8'h80, 1, 1};
        tbl[3] = '{84, 84, 23'h007F00, 8'hF0, 0, 2};
        tbl[4] = '{ 1,  1, 23'h000000, 8'h7F, 1, 0};
        tbl[5] = '{83, 83, 23'h400000, 8'h01, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_err_len", int'(err_len), 0);
        clear_x_exp();
        check("rst_x", int'(x_ok()), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_rise", int'(s_ready), 1);

        s_data = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        check("x_ignore_invalid", int'(x_ok()), 1);

        for (int i = 0; i < 6; i++) begin
            run_vector(tbl[i]);
            if (i == 2) begin
                // After a full buffer without s_last, the next beat opens a new vector.
                err_base = err_seen;
                z_in = 23'h00FF00;
                exp_q.push_back(model_q(z_in));
                send_beat(8'h55, 1'b0);
                clear_x_exp();
                x_exp[0] = 8'h55;
                check("next_vec_x0", int'(x_ok()), 1);
                send_beat(8'h66, 1'b1);
                x_exp[1] = 8'h66;
                check("short_vec_x", int'(x_ok()), 1);
                drain(0, 1, err_base);
            end
        end

        z_in = 23'h000A00;
        for (int i = 0; i < 40; i++) send_beat(8'(i + 1), 1'b0);
        check("idx_at_40", int'(dut.r_idx), 40);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_idx", int'(dut.r_idx), 0);
        clear_x_exp();
        check("abort_x", int'(x_ok()), 1);
        check("abort_s_ready", int'(s_ready), 0);
        lingered = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (m_valid) lingered++;
        end
        check("abort_no_m_valid", lingered, 0);

        run_vector(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
